// File: rtl/mul_iter_pkg.sv
// -----------------------------------------------------------------------------
// mul_iter_pkg
//   Shared definitions for the execute-cluster iterative multiplier.
//   Contents:
//     MUL_WIDTH     - default operand width of the integer multiplier
//     MUL_TAG_WIDTH - default ROB tag width carried through the unit
//     mul_state_t   - control state of the iterative multiplier
// -----------------------------------------------------------------------------
package mul_iter_pkg;

   localparam int MUL_WIDTH     = 32;
   localparam int MUL_TAG_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // waiting for an operand pair
      BUSY = 2'd1,   // one shift-add iteration per cycle
      DONE = 2'd2    // product presented, waiting for the consumer
   } mul_state_t;

endpackage

// File: rtl/mul_iter_adder.sv
// -----------------------------------------------------------------------------
// adder
//   Plain ripple-carry adder used by mul_iter for the accumulate step.
//   The carry-out is not exported: the multiplier sizes the adder one bit
//   wider than the operands, so the top sum bit already holds any carry.
//   Ports:
//     a_i   [WIDTH-1:0] addend
//     b_i   [WIDTH-1:0] addend
//     sum_o [WIDTH-1:0] a_i + b_i, modulo 2**WIDTH
// -----------------------------------------------------------------------------
module adder #(
   parameter int WIDTH = 33
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] sum_o
);

   always_comb begin
      logic carry;
      carry = 1'b0;
      sum_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
   end

endmodule

// File: rtl/mul_iter.sv
// -----------------------------------------------------------------------------
// mul_iter
//   Iterative unsigned shift-add multiplier. Takes one WIDTH x WIDTH operand
//   pair through a valid/ready handshake, retires one multiplier bit per cycle
//   through a single ripple adder, and returns the exact 2*WIDTH-bit product
//   with the ROB tag it was issued with. A flush squashes any operation in
//   flight, including a finished product still waiting in DONE.
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous active-high reset
//     flush        synchronous squash, wins over in_valid and out_ready
//     in_valid     operand pair and tag valid
//     in_ready     unit idle and able to accept (state decode)
//     in_a         multiplicand
//     in_b         multiplier
//     in_tag       ROB tag
//     out_valid    product valid (state decode)
//     out_ready    consumer takes the product
//     out_product  a*b, registered
//     out_tag      tag of the product, registered
//
//   Latency: accept at edge N -> out_valid high after edge N+WIDTH.
// -----------------------------------------------------------------------------
module mul_iter
   import mul_iter_pkg::*;
#(
   parameter int WIDTH     = MUL_WIDTH,
   parameter int TAG_WIDTH = MUL_TAG_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_a,
   input  logic [WIDTH-1:0]       in_b,
   input  logic [TAG_WIDTH-1:0]   in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*WIDTH-1:0]     out_product,
   output logic [TAG_WIDTH-1:0]   out_tag
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mul_state_t             state_q, state_d;
   logic [WIDTH-1:0]       a_q,     a_d;
   logic [WIDTH:0]         h_q,     h_d;
   logic [WIDTH-1:0]       l_q,     l_d;
   logic [CNT_W-1:0]       cnt_q,   cnt_d;
   logic [TAG_WIDTH-1:0]   tag_q,   tag_d;

   logic [WIDTH:0]         addend;
   logic [WIDTH:0]         sum;

   // Partial product for the current multiplier bit. H never exceeds
   // 2**WIDTH-1 entering an iteration, so H + A fits in WIDTH+1 bits.
   assign addend = l_q[0] ? {1'b0, a_q} : '0;

   adder #(
      .WIDTH (WIDTH + 1)
   ) u_adder (
      .a_i   (h_q),
      .b_i   (addend),
      .sum_o (sum)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      h_d     = h_q;
      l_d     = l_q;
      cnt_d   = cnt_q;
      tag_d   = tag_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid && !flush) begin
               a_d     = in_a;
               l_d     = in_b;
               h_d     = '0;
               cnt_d   = '0;
               tag_d   = in_tag;
               state_d = BUSY;
            end
         end

         BUSY: begin
            // {H, L} <= {0, sum, L} >> 1: the low sum bit becomes the next
            // product bit at the top of L while the consumed multiplier bit
            // drops out of L[0]; H[WIDTH] is left clear.
            h_d   = {1'b0, sum[WIDTH:1]};
            l_d   = {sum[0], l_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Squash overrides every transition, including a pending accept or
      // an output handshake in the same cycle.
      if (flush) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         h_q     <= '0;
         l_q     <= '0;
         cnt_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         h_q     <= h_d;
         l_q     <= l_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
      end
   end

   // Outputs come only from registers and state decode. Product and tag are
   // masked outside DONE so the bus reads zero while no result is offered.
   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign out_product = out_valid ? {h_q[WIDTH-1:0], l_q} : '0;
   assign out_tag     = out_valid ? tag_q : '0;

endmodule

// File: tb/tb_mul_iter.sv
// -----------------------------------------------------------------------------
// tb_mul_iter
//   Self-checking bench for mul_iter. Two instances: WIDTH=8 for the directed
//   scenarios and WIDTH=32 for the wide corner case, the mid-operation reset
//   and the randomized run against a transaction-level reference model.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mul_iter;

   localparam int TW = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          f8, iv8, ir8, ov8, or8;
   logic [7:0]    a8, b8;
   logic [TW-1:0] t8, ot8;
   logic [15:0]   p8;

   logic          f32, iv32, ir32, ov32, or32;
   logic [31:0]   a32, b32;
   logic [TW-1:0] t32, ot32;
   logic [63:0]   p32;

   int n_checks = 0;
   int n_fail   = 0;

   mul_iter #(.WIDTH(8), .TAG_WIDTH(TW)) dut8 (
      .clk         (clk),
      .rst         (rst),
      .flush       (f8),
      .in_valid    (iv8),
      .in_ready    (ir8),
      .in_a        (a8),
      .in_b        (b8),
      .in_tag      (t8),
      .out_valid   (ov8),
      .out_ready   (or8),
      .out_product (p8),
      .out_tag     (ot8)
   );

   mul_iter #(.WIDTH(32), .TAG_WIDTH(TW)) dut32 (
      .clk         (clk),
      .rst         (rst),
      .flush       (f32),
      .in_valid    (iv32),
      .in_ready    (ir32),
      .in_a        (a32),
      .in_b        (b32),
      .in_tag      (t32),
      .out_valid   (ov32),
      .out_ready   (or32),
      .out_product (p32),
      .out_tag     (ot32)
   );

   // Reset values of both instances.
   task automatic test_reset();
      rst = 1'b1;
      f8 = 0; iv8 = 0; or8 = 0; a8 = 0; b8 = 0; t8 = 0;
      f32 = 0; iv32 = 0; or32 = 0; a32 = 0; b32 = 0; t32 = 0;
      @(negedge clk);
      n_checks++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0 || p8 !== 16'h0 || ot8 !== '0) begin
         n_fail++;
         $display("FAIL reset8: got rdy=%b vld=%b prod=%h tag=%h, want 1 0 0000 00",
                  ir8, ov8, p8, ot8);
      end
      n_checks++;
      if (ir32 !== 1'b1 || ov32 !== 1'b0 || p32 !== 64'h0 || ot32 !== '0) begin
         n_fail++;
         $display("FAIL reset32: got rdy=%b vld=%b prod=%h tag=%h, want 1 0 0 00",
                  ir32, ov32, p32, ot32);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // One WIDTH=8 operation with out_ready held high: latency, result, tag,
   // and return to idle one cycle after the handshake.
   task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                          input logic [TW-1:0] tag, input string name);
      logic [15:0] exp;
      exp = {8'h00, a} * {8'h00, b};
      iv8 = 1'b1; a8 = a; b8 = b; t8 = tag; or8 = 1'b1;
      n_checks++;
      if (ir8 !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_accept_ready: got %b want 1", name, ir8);
      end
      @(negedge clk);
      // Operands only need to be valid in the accept cycle.
      iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); t8 = TW'($urandom);
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (ov8 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_early_valid: cycle %0d got %b want 0", name, k, ov8);
         end
         @(negedge clk);
      end
      n_checks++;
      if (ov8 !== 1'b1 || p8 !== exp || ot8 !== tag || ir8 !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_result: got vld=%b prod=%h tag=%h rdy=%b, want 1 %h %h 0",
                  name, ov8, p8, ot8, ir8, exp, tag);
      end
      @(negedge clk);
      n_checks++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_idle_after: got rdy=%b vld=%b, want 1 0", name, ir8, ov8);
      end
   endtask

   task automatic test_basic();
      run_op8(8'd3, 8'd5, 6'h2A, "basic_3x5");
   endtask

   task automatic test_corners8();
      run_op8(8'hFF, 8'hFF, 6'h11, "max8");
      run_op8(8'h00, 8'hAB, 6'h3F, "zero8");
      run_op8(8'h80, 8'h01, 6'h01, "msb8");
   endtask

   task automatic test_max32();
      iv32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; t32 = 6'h05; or32 = 1'b1;
      @(negedge clk);
      iv32 = 1'b0; a32 = 0; b32 = 0;
      for (int k = 0; k < 32; k++) begin
         n_checks++;
         if (ov32 !== 1'b0) begin
            n_fail++;
            $display("FAIL max32_early_valid: cycle %0d got %b want 0", k, ov32);
         end
         @(negedge clk);
      end
      n_checks++;
      if (ov32 !== 1'b1 || p32 !== 64'hFFFF_FFFE_0000_0001 || ot32 !== 6'h05) begin
         n_fail++;
         $display("FAIL max32_result: got vld=%b prod=%h tag=%h, want 1 fffffffe00000001 05",
                  ov32, p32, ot32);
      end
      @(negedge clk);
      n_checks++;
      if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
         n_fail++;
         $display("FAIL max32_idle_after: got rdy=%b vld=%b, want 1 0", ir32, ov32);
      end
   endtask

   // Product held under backpressure while a new request waits unaccepted.
   task automatic test_backpressure();
      int waited = 0;
      iv8 = 1'b1; a8 = 8'd13; b8 = 8'd11; t8 = 6'h15; or8 = 1'b0;
      @(negedge clk);
      a8 = 8'd2; b8 = 8'd2; t8 = 6'h00;
      while (ov8 !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (ov8 !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_timeout: out_valid got %b want 1 within 20 cycles", ov8);
      end
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (ov8 !== 1'b1 || p8 !== 16'd143 || ot8 !== 6'h15 || ir8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: cycle %0d got vld=%b prod=%h tag=%h rdy=%b, want 1 008f 15 0",
                     i, ov8, p8, ot8, ir8);
         end
         @(negedge clk);
      end
      or8 = 1'b1; iv8 = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: got vld=%b rdy=%b, want 0 1", ov8, ir8);
      end
      @(negedge clk);
      n_checks++;
      if (ov8 !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_single_handshake: got vld=%b want 0", ov8);
      end
   endtask

   // Flush in the third BUSY cycle with a competing request, then flush of a
   // finished product in DONE, then a normal operation.
   task automatic test_flush();
      bit seen = 0;
      iv8 = 1'b1; a8 = 8'd9; b8 = 8'd9; t8 = 6'h01; or8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      f8 = 1'b1; iv8 = 1'b1; a8 = 8'd2; b8 = 8'd2; t8 = 6'h03;
      @(negedge clk);
      f8 = 1'b0; iv8 = 1'b0;
      n_checks++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_busy_idle: got rdy=%b vld=%b, want 1 0", ir8, ov8);
      end
      for (int i = 0; i < 20; i++) begin
         if (ov8 === 1'b1) seen = 1;
         @(negedge clk);
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL flush_busy_no_output: out_valid got 1 want 0");
      end

      iv8 = 1'b1; a8 = 8'd4; b8 = 8'd4; t8 = 6'h07; or8 = 1'b0;
      @(negedge clk);
      iv8 = 1'b0;
      repeat (8) @(negedge clk);
      n_checks++;
      if (ov8 !== 1'b1 || p8 !== 16'd16) begin
         n_fail++;
         $display("FAIL flush_done_pre: got vld=%b prod=%h, want 1 0010", ov8, p8);
      end
      f8 = 1'b1; or8 = 1'b1;
      @(negedge clk);
      f8 = 1'b0;
      n_checks++;
      if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_done_drop: got vld=%b rdy=%b, want 0 1", ov8, ir8);
      end
      run_op8(8'd6, 8'd7, 6'h09, "after_flush_6x7");
   endtask

   // Asynchronous reset with dut32 mid-BUSY and dut8 holding a product.
   task automatic test_reset_mid();
      bit seen = 0;
      iv32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; t32 = 6'h22; or32 = 1'b1;
      iv8  = 1'b1; a8  = 8'd10; b8 = 8'd10; t8 = 6'h2B; or8 = 1'b0;
      @(negedge clk);
      iv32 = 1'b0; iv8 = 1'b0;
      repeat (9) @(negedge clk);
      n_checks++;
      if (ov8 !== 1'b1 || ir32 !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_pre: got vld8=%b rdy32=%b, want 1 0", ov8, ir32);
      end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (ir32 !== 1'b1 || ov32 !== 1'b0 || p32 !== 64'h0 || ot32 !== '0) begin
         n_fail++;
         $display("FAIL rstmid_32: got rdy=%b vld=%b prod=%h tag=%h, want 1 0 0 00",
                  ir32, ov32, p32, ot32);
      end
      n_checks++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0 || p8 !== 16'h0 || ot8 !== '0) begin
         n_fail++;
         $display("FAIL rstmid_8: got rdy=%b vld=%b prod=%h tag=%h, want 1 0 0000 00",
                  ir8, ov8, p8, ot8);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ov32 === 1'b1 || ov8 === 1'b1) seen = 1;
         @(negedge clk);
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL rstmid_no_output: out_valid rose after reset abort");
      end
   endtask

   // Randomized WIDTH=32 traffic. The model knows only the contract: one
   // operation in flight, result offered WIDTH edges after the accept,
   // product = a*b with the issued tag, held until taken.
   task automatic test_random32();
      logic [63:0]   q_prod[$];
      logic [TW-1:0] q_tag[$];
      logic [63:0]   ea, eb;
      int  issued = 0, retired = 0, cycles = 0, since = 0;
      bit  pending = 0;
      bit  acc, hs;
      while (retired < 2000 && cycles < 85000) begin
         n_checks++;
         if (ir32 !== !pending || ov32 !== (pending && since >= 32)) begin
            n_fail++;
            $display("FAIL rand_ctrl: op %0d got rdy=%b vld=%b, want %b %b",
                     retired, ir32, ov32, !pending, pending && since >= 32);
         end
         iv32 = (issued < 2000) && ($urandom_range(0, 7) != 0);
         or32 = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 7))
            0:       a32 = 32'h0;
            1:       a32 = 32'hFFFF_FFFF;
            default: a32 = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       b32 = 32'hFFFF_FFFF;
            1:       b32 = 32'h1;
            default: b32 = $urandom;
         endcase
         t32 = TW'($urandom);
         acc = iv32 && !pending;
         hs  = pending && since >= 32 && or32;
         if (hs) begin
            n_checks++;
            if (q_prod.size() == 0) begin
               n_fail++;
               $display("FAIL rand_underflow: output offered with nothing issued");
            end else begin
               if (p32 !== q_prod[0] || ot32 !== q_tag[0]) begin
                  n_fail++;
                  $display("FAIL rand_result: op %0d got prod=%h tag=%h, want %h %h",
                           retired, p32, ot32, q_prod[0], q_tag[0]);
               end
               void'(q_prod.pop_front());
               void'(q_tag.pop_front());
            end
            retired++;
            pending = 0;
         end
         if (acc) begin
            ea = {32'h0, a32};
            eb = {32'h0, b32};
            q_prod.push_back(ea * eb);
            q_tag.push_back(t32);
            issued++;
            pending = 1;
            since = -1;
         end
         @(negedge clk);
         cycles++;
         if (pending) since++;
      end
      iv32 = 1'b0;
      n_checks++;
      if (retired != 2000) begin
         n_fail++;
         $display("FAIL rand_timeout: retired %0d want 2000", retired);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners8();
      test_max32();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random32();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
